mem_access_unit: RTL and testbench

- Load/store front end between the multi-cycle MIPS datapath and the word-addressed RAM.
- Accepts one byte-addressed request at a time: LW/LH/LHU/LB/LBU/SW/SH/SB.
- Converts the byte address to a word address and extracts/extends load data.
- Performs a read-modify-write for sub-word stores, because the RAM only writes whole words.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_lane_align.sv | 46 ++++
 rtl/mem_access_unit.sv | 109 ++++++++++
 tb/tb_mem_access_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store front end.
package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int OFF_W      = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } mau_state_e;

  function automatic logic is_load(mem_op_e op);
    return op inside {LW, LH, LHU, LB, LBU};
  endfunction

  function automatic logic is_aligned(mem_op_e op, logic [OFF_W-1:0] offset);
    case (op)
      LW, SW:      return offset == '0;
      LH, LHU, SH: return !offset[0];
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the word-RAM port of the load/store unit.
interface mem_access_unit_if #(parameter int RAM_ADDR_WIDTH = 10);
  import mem_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  mem_op_e                   req_op;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  logic                      resp_valid;
  logic [31:0]               resp_rdata;
  logic                      resp_err;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]               ram_wr_data;
  logic                      ram_wr_en;
  logic [31:0]               ram_rd_data;

  // The master side is the datapath plus the RAM model.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, ram_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           ram_addr, ram_wr_data, ram_wr_en
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, ram_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           ram_addr, ram_wr_data, ram_wr_en
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane select/extend for loads and byte/halfword merge for stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0]      word_i,
  input  logic [OFF_W-1:0] offset_i,
  input  mem_op_e          op_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      load_o,
  output logic [31:0]      store_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word_i[{offset_i, 3'b000} +: 8];
  assign half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    load_o = word_i;
    case (op_i)
      LB:      load_o = {{24{byte_lane[7]}}, byte_lane};
      LBU:     load_o = {24'h0, byte_lane};
      LH:      load_o = {{16{half_lane[15]}}, half_lane};
      LHU:     load_o = {16'h0, half_lane};
      default: load_o = word_i;
    endcase
  end

  // Sub-word stores rewrite only their own lane of the word just read.
  always_comb begin
    store_o = wdata_i;
    case (op_i)
      SB: begin
        store_o = word_i;
        store_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SH: begin
        store_o = word_i;
        store_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word RAM; sub-word stores use read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 10
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);

  mau_state_e                state_q, state_d;
  mem_op_e                   op_q, op_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [OFF_W-1:0]          off_q, off_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wr_data_q, wr_data_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [31:0]               load_val;
  logic [31:0]               store_word;
  logic                      unused_addr_hi;

  // Address bits above the RAM range are dropped so accesses wrap.
  assign unused_addr_hi = ^bus.req_addr[31:RAM_ADDR_WIDTH+2];

  mem_lane_align u_align (
    .word_i   (bus.ram_rd_data),
    .offset_i (off_q),
    .op_i     (op_q),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .store_o  (store_word)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    off_d     = off_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          wdata_d = bus.req_wdata;
          off_d   = bus.req_addr[OFF_W-1:0];
          addr_d  = bus.req_addr[RAM_ADDR_WIDTH+1:2];
          rdata_d = '0;
          err_d   = !is_aligned(bus.req_op, bus.req_addr[OFF_W-1:0]);
          if (!is_aligned(bus.req_op, bus.req_addr[OFF_W-1:0])) begin
            state_d = RESP;
          end else if (bus.req_op == SW) begin
            wr_data_d = bus.req_wdata;
            state_d   = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (is_load(op_q)) begin
          rdata_d = load_val;
          state_d = RESP;
        end else begin
          wr_data_d = store_word;
          state_d   = WR;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= LW;
      wdata_q   <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.ram_wr_en   = (state_q == WR);
  assign bus.resp_valid  = (state_q == RESP);
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word RAM.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   wr_cnt;
  int   resp_cnt;
  logic [31:0] mem [0:1023];

  mem_access_unit_if #(.RAM_ADDR_WIDTH(10)) bus ();

  mem_access_unit #(.RAM_ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ram_rd_data = mem[bus.ram_addr];

  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wr_data;
  end

  initial begin
    wr_cnt   = 0;
    resp_cnt = 0;
  end
  always @(posedge clk) begin
    if (bus.ram_wr_en === 1'b1) wr_cnt = wr_cnt + 1;
    if (bus.resp_valid === 1'b1) resp_cnt = resp_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and run it to completion.
  task automatic issue(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er, output int wrs);
    int w0;
    w0            = wr_cnt;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    step();
    wrs = wr_cnt - w0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = LW;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    step();
    step();
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
    end
    n_cmp++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h %b %h %b %h %h expected all zero", bus.resp_valid,
               bus.resp_err, bus.resp_rdata, bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    int lat, wrs;
    logic [31:0] rd;
    logic er;
    issue(SW, 32'h14, 32'h8899AABB, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || wrs !== 1) begin
      n_bad++;
      $display("FAIL sw_resp: got lat=%0d err=%b rdata=%h writes=%0d expected 2 0 0 1", lat, er, rd, wrs);
    end
    n_cmp++;
    if (mem[5] !== 32'h8899AABB) begin
      n_bad++;
      $display("FAIL sw_mem: got %h expected 8899aabb", mem[5]);
    end
    issue(LW, 32'h14, 32'h0, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 2 || rd !== 32'h8899AABB || er !== 1'b0 || wrs !== 0) begin
      n_bad++;
      $display("FAIL lw_read: got lat=%0d rdata=%h err=%b writes=%0d expected 2 8899aabb 0 0", lat, rd, er, wrs);
    end
  endtask

  task automatic test_byte_load();
    int lat, wrs;
    logic [31:0] rd;
    logic er;
    issue(LB, 32'h15, 32'h0, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 2 || rd !== 32'hFFFFFFAA || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lb_sign: got lat=%0d rdata=%h err=%b expected 2 ffffffaa 0", lat, rd, er);
    end
    issue(LBU, 32'h15, 32'h0, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 2 || rd !== 32'h000000AA || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lbu_zero: got lat=%0d rdata=%h err=%b expected 2 000000aa 0", lat, rd, er);
    end
    issue(LBU, 32'h17, 32'h0, lat, rd, er, wrs);
    n_cmp++;
    if (rd !== 32'h00000088) begin
      n_bad++;
      $display("FAIL lbu_lane3: got %h expected 00000088", rd);
    end
  endtask

  task automatic test_byte_store();
    int lat, wrs;
    logic [31:0] rd;
    logic er;
    issue(SB, 32'h16, 32'h123456CC, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 3 || wrs !== 1 || rd !== 32'h0 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_resp: got lat=%0d writes=%0d rdata=%h err=%b expected 3 1 0 0", lat, wrs, rd, er);
    end
    n_cmp++;
    if (mem[5] !== 32'h88CCAABB) begin
      n_bad++;
      $display("FAIL sb_merge: got %h expected 88ccaabb", mem[5]);
    end
  endtask

  task automatic test_half();
    int lat, wrs;
    logic [31:0] rd;
    logic er;
    issue(SH, 32'h14, 32'h0000BEEF, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 3 || wrs !== 1 || mem[5] !== 32'h88CCBEEF) begin
      n_bad++;
      $display("FAIL sh_merge: got lat=%0d writes=%0d word=%h expected 3 1 88ccbeef", lat, wrs, mem[5]);
    end
    issue(LH, 32'h14, 32'h0, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 2 || rd !== 32'hFFFFBEEF || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lh_sign: got lat=%0d rdata=%h err=%b expected 2 ffffbeef 0", lat, rd, er);
    end
    issue(LHU, 32'h16, 32'h0, lat, rd, er, wrs);
    n_cmp++;
    if (rd !== 32'h000088CC || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lhu_upper: got rdata=%h err=%b expected 000088cc 0", rd, er);
    end
  endtask

  task automatic test_misaligned();
    int lat, wrs;
    logic [31:0] rd;
    logic er;
    issue(SW, 32'h03, 32'hFFFFFFFF, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wrs !== 0) begin
      n_bad++;
      $display("FAIL sw_misaligned: got lat=%0d err=%b rdata=%h writes=%0d expected 1 1 0 0", lat, er, rd, wrs);
    end
    issue(LW, 32'h02, 32'h0, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wrs !== 0) begin
      n_bad++;
      $display("FAIL lw_misaligned: got lat=%0d err=%b rdata=%h writes=%0d expected 1 1 0 0", lat, er, rd, wrs);
    end
    issue(SH, 32'h15, 32'h1111, lat, rd, er, wrs);
    n_cmp++;
    if (lat !== 1 || er !== 1'b1 || wrs !== 0 || mem[5] !== 32'h88CCBEEF) begin
      n_bad++;
      $display("FAIL sh_misaligned: got lat=%0d err=%b writes=%0d word=%h expected 1 1 0 88ccbeef", lat, er, wrs, mem[5]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, wrs, w0, r0;
    logic [31:0] rd;
    logic er;
    logic [5:0] pat;
    issue(SW, 32'h04, 32'h0, lat, rd, er, wrs);
    w0            = wr_cnt;
    r0            = resp_cnt;
    pat           = '0;
    bus.req_op    = SW;
    bus.req_addr  = 32'h00001004;
    bus.req_wdata = 32'hDEADBEEF;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      pat = {pat[4:0], bus.req_ready};
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (pat !== 6'b001001) begin
      n_bad++;
      $display("FAIL hold_ready_pattern: got %b expected 001001", pat);
    end
    n_cmp++;
    if (wr_cnt - w0 !== 2 || resp_cnt - r0 !== 2) begin
      n_bad++;
      $display("FAIL hold_accepts: got writes=%0d resps=%0d expected 2 2", wr_cnt - w0, resp_cnt - r0);
    end
    n_cmp++;
    if (mem[1] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL wrap_word1: got %h expected deadbeef", mem[1]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, wrs, w0, r0;
    logic [31:0] rd;
    logic er;
    issue(SW, 32'h08, 32'h11223344, lat, rd, er, wrs);
    issue(LW, 32'h08, 32'h0, lat, rd, er, wrs);
    w0            = wr_cnt;
    r0            = resp_cnt;
    bus.req_op    = SB;
    bus.req_addr  = 32'h09;
    bus.req_wdata = 32'h000000AB;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_busy: got ready=%b expected 0", bus.req_ready);
    end
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    n_cmp++;
    if (wr_cnt !== w0 || resp_cnt !== r0) begin
      n_bad++;
      $display("FAIL mid_abort: got writes=%0d resps=%0d expected %0d %0d", wr_cnt, resp_cnt, w0, r0);
    end
    n_cmp++;
    if (mem[2] !== 32'h11223344) begin
      n_bad++;
      $display("FAIL mid_mem: got %h expected 11223344", mem[2]);
    end
    n_cmp++;
    if (bus.req_ready !== 1'b1 || {bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.ram_wr_en,
                                   bus.ram_addr, bus.ram_wr_data} !== '0) begin
      n_bad++;
      $display("FAIL mid_outputs: got ready=%b rv=%b err=%b rdata=%h we=%b addr=%h wd=%h expected 1 and zeros",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.ram_wr_en,
               bus.ram_addr, bus.ram_wr_data);
    end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_store_word();
    test_byte_load();
    test_byte_store();
    test_half();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
